// File: rtl/inv_result_collector.sv
// Collects the inverter's serial N*N result stream into a local buffer and serves it
// through a registered random-access port, flagging timeout, early finish and saturation.
module inv_result_collector #(
  parameter int N       = 3,
  parameter int SIZE    = 16,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            inv_done_i,
  input  logic            inv_finish_i,
  input  logic [SIZE-1:0] inv_data_i,
  output logic            inv_read_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic            sat_o,
  input  logic [3:0]      rd_addr_i,
  output logic [SIZE-1:0] rd_data_o
);
  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   NN_C    = CW'(NN);
  localparam logic [SIZE-1:0] POS_MAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] NEG_MAX = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DONE, S_READ, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     issueCnt_q, issueCnt_d;
  logic [CW-1:0]     capCnt_q, capNext;
  logic [1:0]        errCode_q, errCode_d;
  logic              sat_q, invRead_q;
  logic              clearAll, capEn, satHit;
  logic [RD_LAT-1:0] rdPipe_q;
  logic [SIZE-1:0]   resBuf_q [NN];
  logic [SIZE-1:0]   rdData_q;

  // A word is only taken while collecting, so in-flight words after an abort are dropped
  always_comb begin
    capEn   = rdPipe_q[RD_LAT-1] && ((state_q == S_READ) || (state_q == S_DRAIN))
              && (capCnt_q != NN_C);
    satHit  = capEn && ((inv_data_i == POS_MAX) || (inv_data_i == NEG_MAX));
    capNext = capCnt_q + CW'(capEn);
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    issueCnt_d = issueCnt_q;
    errCode_d  = errCode_q;
    clearAll   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_WAIT_DONE;
          clearAll   = 1'b1;
          timer_d    = '0;
          issueCnt_d = '0;
          errCode_d  = 2'd0;
        end
      end
      S_WAIT_DONE: begin
        if (inv_done_i) begin
          state_d = S_READ;
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d   = S_ERR;
          errCode_d = 2'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_READ: begin
        if (issueCnt_q != NN_C) issueCnt_d = issueCnt_q + CW'(1);
        if (inv_finish_i) begin
          state_d   = S_ERR;
          errCode_d = 2'd2;
        end else if (issueCnt_q == NN_C - CW'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Looking at the post-capture count lets valid rise one cycle after the last word
        if (capNext == NN_C) begin
          state_d = S_DONE;
        end else if (inv_finish_i) begin
          state_d   = S_ERR;
          errCode_d = 2'd2;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      issueCnt_q <= '0;
      capCnt_q   <= '0;
      errCode_q  <= 2'd0;
      sat_q      <= 1'b0;
      invRead_q  <= 1'b0;
      rdPipe_q   <= '0;
      rdData_q   <= '0;
      for (int i = 0; i < NN; i++) resBuf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      issueCnt_q <= issueCnt_d;
      errCode_q  <= errCode_d;
      invRead_q  <= (state_d == S_READ);
      rdData_q   <= (32'(rd_addr_i) < NN) ? resBuf_q[rd_addr_i] : '0;
      if (clearAll) begin
        capCnt_q <= '0;
        sat_q    <= 1'b0;
        rdPipe_q <= '0;
      end else begin
        capCnt_q    <= capNext;
        sat_q       <= sat_q | satHit;
        rdPipe_q[0] <= invRead_q;
        for (int i = 1; i < RD_LAT; i++) rdPipe_q[i] <= rdPipe_q[i-1];
        if (capEn) resBuf_q[capCnt_q] <= inv_data_i;
      end
    end
  end

  assign inv_read_o = invRead_q;
  assign busy_o     = (state_q == S_WAIT_DONE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign valid_o    = (state_q == S_DONE);
  assign err_o      = (state_q == S_ERR);
  assign err_code_o = errCode_q;
  assign sat_o      = sat_q;
  assign rd_data_o  = rdData_q;
endmodule

// File: tb/tb_inv_result_collector.sv
// Bench for inv_result_collector: two instances (read latency 1 and 3) share control
// inputs, each fed by its own latency-matched inverter stream model.
module tb_inv_result_collector;
  localparam int NN  = 9;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst, start, invDone, invFinish, modelClear;
  logic [3:0]  rdAddr;
  logic        invReadA, busyA, validA, errA, satA;
  logic        invReadB, busyB, validB, errB, satB;
  logic [1:0]  errCodeA, errCodeB;
  logic [15:0] invDataA, invDataB, rdDataA, rdDataB;

  logic [15:0] streamA [NN];
  logic [15:0] streamB [NN];
  logic [15:0] expBufA [NN];
  logic [15:0] expBufB [NN];
  logic        histA;
  logic [2:0]  histB;
  int          idxA, idxB;
  logic [15:0] junkA, junkB;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  inv_result_collector #(.N(3), .SIZE(16), .RD_LAT(1), .TIMEOUT(TMO)) dutA (
    .clk_i(clk), .rst_i(rst), .start_i(start), .inv_done_i(invDone),
    .inv_finish_i(invFinish), .inv_data_i(invDataA), .inv_read_o(invReadA),
    .busy_o(busyA), .valid_o(validA), .err_o(errA), .err_code_o(errCodeA),
    .sat_o(satA), .rd_addr_i(rdAddr), .rd_data_o(rdDataA));

  inv_result_collector #(.N(3), .SIZE(16), .RD_LAT(3), .TIMEOUT(TMO)) dutB (
    .clk_i(clk), .rst_i(rst), .start_i(start), .inv_done_i(invDone),
    .inv_finish_i(invFinish), .inv_data_i(invDataB), .inv_read_o(invReadB),
    .busy_o(busyB), .valid_o(validB), .err_o(errB), .err_code_o(errCodeB),
    .sat_o(satB), .rd_addr_i(rdAddr), .rd_data_o(rdDataB));

  // Inverter side: a word appears exactly RD_LAT cycles after its read, junk otherwise
  always @(posedge clk or posedge rst) begin
    if (rst || modelClear) begin
      histA <= 1'b0;
      histB <= 3'b000;
      idxA  <= 0;
      idxB  <= 0;
    end else begin
      histA <= invReadA;
      histB <= {histB[1:0], invReadB};
      if (histA) idxA <= idxA + 1;
      if (histB[2]) idxB <= idxB + 1;
    end
  end

  always @(posedge clk) begin
    junkA <= 16'($urandom);
    junkB <= 16'($urandom);
  end

  assign invDataA = (histA && idxA < NN) ? streamA[idxA] : junkA;
  assign invDataB = (histB[2] && idxB < NN) ? streamB[idxB] : junkB;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randStreams(input bit withSat);
    for (int k = 0; k < NN; k++) begin
      streamA[k] = 16'($urandom);
      streamB[k] = 16'($urandom);
      if (withSat && $urandom_range(0, 7) == 0) streamA[k] = 16'h7FFF;
      if (withSat && $urandom_range(0, 7) == 0) streamB[k] = 16'h8000;
    end
  endtask

  task automatic sweepPort();
    logic [15:0] expA, expB;
    for (int a = 0; a < 12; a++) begin
      @(negedge clk);
      rdAddr = (a == 11) ? 4'd15 : 4'(a);
      @(negedge clk);
      expA = 16'h0;
      expB = 16'h0;
      if (a < NN) begin
        expA = expBufA[a];
        expB = expBufB[a];
      end
      checkOutput($sformatf("rdDataA[%0d]", rdAddr), rdDataA, expA);
      checkOutput($sformatf("rdDataB[%0d]", rdAddr), rdDataB, expB);
    end
  endtask

  // One collection: doneDelay>=TMO means done never comes; finishAt/startAt are read-cycle numbers
  task automatic applyStimulus(input int doneDelay, input int finishAt, input int startAt);
    int   capA, capB, rdCntA, rdCntB, lastRdA, lastRdB, riseA, riseB, errCycA, errCycB;
    logic earlyRd, expSatA, expSatB;
    capA = 0; capB = 0; rdCntA = 0; rdCntB = 0; lastRdA = 0; lastRdB = 0;
    riseA = -1; riseB = -1; errCycA = -1; errCycB = -1;
    earlyRd = 1'b0;
    @(negedge clk); start = 1'b1; modelClear = 1'b1;
    @(negedge clk); start = 1'b0; modelClear = 1'b0;
    checkOutput("busyArmA", busyA, 1);
    checkOutput("busyArmB", busyB, 1);
    checkOutput("validArmA", validA, 0);
    checkOutput("errArmB", errB, 0);
    if (doneDelay >= TMO) begin
      for (int i = 0; i < TMO - 1; i++) begin
        earlyRd |= invReadA | invReadB;
        @(negedge clk);
      end
      checkOutput("errPreTmoA", errA, 0);
      earlyRd |= invReadA | invReadB;
      @(negedge clk);
      earlyRd |= invReadA | invReadB;
      checkOutput("errTmoA", errA, 1);
      checkOutput("errTmoB", errB, 1);
      checkOutput("codeTmoA", errCodeA, 1);
      checkOutput("codeTmoB", errCodeB, 1);
      checkOutput("validTmoA", validA, 0);
      checkOutput("noReadTmo", earlyRd, 0);
    end else begin
      for (int i = 0; i < doneDelay; i++) begin
        earlyRd |= invReadA | invReadB;
        @(negedge clk);
      end
      earlyRd |= invReadA | invReadB;
      checkOutput("noEarlyRead", earlyRd, 0);
      invDone = 1'b1;
      @(negedge clk);
      invDone = 1'b0;
      checkOutput("firstReadA", invReadA, 1);
      checkOutput("firstReadB", invReadB, 1);
      for (int c = 1; c <= 60; c++) begin
        if (invReadA) begin rdCntA++; lastRdA = c; end
        if (invReadB) begin rdCntB++; lastRdB = c; end
        if (validA && riseA < 0) riseA = c;
        if (validB && riseB < 0) riseB = c;
        if (errA && errCycA < 0) errCycA = c;
        if (errB && errCycB < 0) errCycB = c;
        if ((validA || errA) && (validB || errB)) break;
        invFinish = (c == finishAt);
        start     = (c == startAt);
        @(negedge clk);
      end
      invFinish = 1'b0;
      start     = 1'b0;
      if (finishAt > 0) begin
        capA = (finishAt > 1) ? finishAt - 1 : 0;
        capB = (finishAt > 3) ? finishAt - 3 : 0;
        checkOutput("errFinA", errA, 1);
        checkOutput("errFinB", errB, 1);
        checkOutput("codeFinA", errCodeA, 2);
        checkOutput("codeFinB", errCodeB, 2);
        checkOutput("validFinA", validA, 0);
        checkOutput("validFinB", validB, 0);
        checkOutput("readsFinA", rdCntA, finishAt);
        checkOutput("dropCycleA", errCycA, finishAt + 1);
        checkOutput("dropCycleB", errCycB, finishAt + 1);
      end else begin
        capA = NN;
        capB = NN;
        checkOutput("validA", validA, 1);
        checkOutput("validB", validB, 1);
        checkOutput("errA", errA, 0);
        checkOutput("codeB", errCodeB, 0);
        checkOutput("readsA", rdCntA, NN);
        checkOutput("readsB", rdCntB, NN);
        checkOutput("validLatA", riseA - lastRdA, 2);
        checkOutput("validLatB", riseB - lastRdB, 4);
      end
    end
    checkOutput("busyEndA", busyA, 0);
    checkOutput("busyEndB", busyB, 0);
    expSatA = 1'b0;
    expSatB = 1'b0;
    for (int k = 0; k < capA; k++) begin
      expBufA[k] = streamA[k];
      if (streamA[k] == 16'h7FFF || streamA[k] == 16'h8000) expSatA = 1'b1;
    end
    for (int k = 0; k < capB; k++) begin
      expBufB[k] = streamB[k];
      if (streamB[k] == 16'h7FFF || streamB[k] == 16'h8000) expSatB = 1'b1;
    end
    checkOutput("satA", satA, expSatA);
    checkOutput("satB", satB, expSatB);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "ReadA"}, invReadA, 0);
    checkOutput({tag, "ReadB"}, invReadB, 0);
    checkOutput({tag, "BusyA"}, busyA, 0);
    checkOutput({tag, "ValidB"}, validB, 0);
    checkOutput({tag, "ErrA"}, errA, 0);
    checkOutput({tag, "CodeA"}, errCodeA, 0);
    checkOutput({tag, "SatA"}, satA, 0);
    checkOutput({tag, "SatB"}, satB, 0);
    checkOutput({tag, "RdDataA"}, rdDataA, 0);
    checkOutput({tag, "RdDataB"}, rdDataB, 0);
  endtask

  task automatic resetMidRead();
    rdAddr = 4'd0;
    @(negedge clk); start = 1'b1; modelClear = 1'b1;
    @(negedge clk); start = 1'b0; modelClear = 1'b0;
    invDone = 1'b1;
    @(negedge clk);
    invDone = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("preRstSatA", satA, 1);
    checkOutput("preRstReadA", invReadA, 1);
    rst = 1'b1;
    #1;
    checkAllZero("midRst");
    for (int k = 0; k < NN; k++) begin
      expBufA[k] = 16'h0;
      expBufB[k] = 16'h0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fin, st;
    rst = 1'b1; start = 1'b0; invDone = 1'b0; invFinish = 1'b0;
    modelClear = 1'b0; rdAddr = 4'd0;
    for (int k = 0; k < NN; k++) begin
      expBufA[k] = 16'h0;
      expBufB[k] = 16'h0;
      streamA[k] = 16'h0;
      streamB[k] = 16'h0;
    end
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    streamA = '{16'h0AAB, 16'hFAAB, 16'h0000, 16'hFAAB, 16'h0AAB,
                16'h0000, 16'h0000, 16'hF000, 16'h1000};
    for (int k = 0; k < NN; k++) streamB[k] = 16'(k + 1);
    applyStimulus(20, 0, 0);
    sweepPort();

    applyStimulus(TMO, 0, 0);
    sweepPort();

    randStreams(1'b0);
    applyStimulus(7, 5, 0);
    sweepPort();

    randStreams(1'b0);
    streamA[4] = 16'h8000;
    streamB[4] = 16'h8000;
    applyStimulus(3, 0, 3);
    sweepPort();

    randStreams(1'b0);
    streamA[0] = 16'h7FFF;
    streamB[0] = 16'h7FFF;
    resetMidRead();
    sweepPort();
    randStreams(1'b0);
    applyStimulus(5, 0, 0);
    sweepPort();

    for (int t = 0; t < 8; t++) begin
      randStreams(1'b1);
      fin = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      st  = (fin == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : 0;
      applyStimulus(int'($urandom_range(0, 40)), fin, st);
      sweepPort();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
